// File: rtl/ext_bus_ctrl_if.sv
// CPU-side and external-slave-side signals of the external bus controller.
// The master modport is the controller's view; the slave modport is the CPU plus external slave.
interface ext_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cs;
    logic              wr_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_bus_write;
    logic [DATA_W-1:0] data_bus_read;
    logic              stall;
    logic              err;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_ack;

    modport master (
        input  cs, wr_rd, addr, data_bus_write, ext_rdata, ext_ack,
        output data_bus_read, stall, err, ext_req, ext_we, ext_addr, ext_wdata
    );

    modport slave (
        output cs, wr_rd, addr, data_bus_write, ext_rdata, ext_ack,
        input  data_bus_read, stall, err, ext_req, ext_we, ext_addr, ext_wdata
    );
endinterface

// File: rtl/ext_bus_ctrl.sv
// Memory-stage controller for external-space accesses: latches the CPU access,
// runs a four-phase req/ack handshake with timeout, and stalls the pipeline meanwhile.
module ext_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    ext_bus_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ext_req;
    logic              r_ext_we;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [DATA_W-1:0] r_ext_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_stall;

    // Handshake sequencer; r_err doubles as the timeout flag and is only ever high in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ext_req   <= 1'b0;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cs) begin
                        r_ext_addr  <= bus.addr;
                        r_ext_wdata <= bus.data_bus_write;
                        r_ext_we    <= bus.wr_rd;
                        r_ext_req   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus.ext_ack) begin
                        if (!r_ext_we) begin
                            r_rdata <= bus.ext_rdata;
                        end
                        r_ext_req <= 1'b0;
                        r_state   <= S_RELEASE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        if (!r_ext_we) begin
                            r_rdata <= '0;
                        end
                        r_ext_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_RELEASE: begin
                    // Counter keeps running so a stuck ack cannot hold the pipeline forever.
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!bus.ext_ack) begin
                        r_state <= S_DONE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the cs cycle itself is frozen.
    assign w_stall = ((r_state == S_IDLE) && bus.cs)
                   || (r_state == S_REQ)
                   || (r_state == S_RELEASE);

    assign bus.stall         = w_stall;
    assign bus.err           = r_err;
    assign bus.ext_req       = r_ext_req;
    assign bus.ext_we        = r_ext_we;
    assign bus.ext_addr      = r_ext_addr;
    assign bus.ext_wdata     = r_ext_wdata;
    assign bus.data_bus_read = r_rdata;
endmodule
